// File: rtl/ddr2_power_pkg.sv
// ddr2_power_pkg: shared state encoding, command encodings and timer width for the DDR2 power controller.
package ddr2_power_pkg;
    localparam int TIMER_W = 8;
    typedef enum logic [2:0] {
        ST_ACTIVE,
        ST_HOLD,
        ST_PD_ENTER,
        ST_PD,
        ST_PD_EXIT,
        ST_SR_CMD,
        ST_SR,
        ST_SR_EXIT
    } pwr_state_e;
    // {cs#, ras#, cas#, we#}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_DES = 4'b1111;
endpackage

// File: rtl/ddr2_power_timer.sv
// ddr2_power_timer: loadable down-counter that holds at zero.
//   clk, reset   : clock, synchronous active-high reset
//   load, value  : load value into the counter this cycle
//   done         : counter is zero
module ddr2_power_timer
    import ddr2_power_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               done
);
    logic [TIMER_W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign done = cnt == '0;
endmodule

// File: rtl/ddr2_power_ctrl.sv
// ddr2_power_ctrl: sequences DDR2 precharge power-down and self-refresh via CKE.
//   clk, reset                      : clock, synchronous active-high reset
//   eng_idle, pd_en, sr_req, wake_req: engine status and power requests
//   eng_hold, bus_own               : engine stall and pad-mux select
//   cke_pad .. webar_pad            : DRAM CKE and command pins
//   pd_active, sr_active            : low-power status
module ddr2_power_ctrl
    import ddr2_power_pkg::*;
#(
    parameter int unsigned IDLE_THRESH = 16,
    parameter int unsigned T_CKE       = 3,
    parameter int unsigned T_XP        = 2,
    parameter int unsigned T_XSNR      = 140
) (
    input  logic clk,
    input  logic reset,
    input  logic eng_idle,
    input  logic pd_en,
    input  logic sr_req,
    input  logic wake_req,
    output logic eng_hold,
    output logic bus_own,
    output logic cke_pad,
    output logic csbar_pad,
    output logic rasbar_pad,
    output logic casbar_pad,
    output logic webar_pad,
    output logic pd_active,
    output logic sr_active
);
    localparam logic [TIMER_W-1:0] IDLE_LAST = TIMER_W'(IDLE_THRESH - 1);
    localparam logic [TIMER_W-1:0] CKE_LOAD  = TIMER_W'(T_CKE - 1);
    localparam logic [TIMER_W-1:0] XP_LOAD   = TIMER_W'(T_XP - 1);
    localparam logic [TIMER_W-1:0] XSNR_LOAD = TIMER_W'(T_XSNR - 1);

    pwr_state_e         state, next;
    logic               tgt_sr, tgt_sr_next;
    logic [TIMER_W-1:0] idle_cnt;
    logic               tmr_load, tmr_done;
    logic [TIMER_W-1:0] tmr_value;

    // Every state change reloads the timer; only the timed states care about the value.
    assign tmr_load  = next != state;
    assign tmr_value = next == ST_PD_EXIT ? XP_LOAD : next == ST_SR_EXIT ? XSNR_LOAD : CKE_LOAD;

    ddr2_power_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_ACTIVE;
            tgt_sr <= 1'b0;
        end else begin
            state  <= next;
            tgt_sr <= tgt_sr_next;
        end
    end

    always_ff @(posedge clk)
        if (reset || !(state == ST_ACTIVE && eng_idle && pd_en)) idle_cnt <= '0;
        else if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;

    always_comb begin
        next        = state;
        tgt_sr_next = tgt_sr;
        case (state)
            ST_ACTIVE:
                if (sr_req && eng_idle) begin
                    next        = ST_HOLD;
                    tgt_sr_next = 1'b1;
                end else if (idle_cnt == IDLE_LAST && eng_idle && !wake_req) begin
                    next        = ST_HOLD;
                    tgt_sr_next = 1'b0;
                end
            ST_HOLD:     next = !eng_idle ? ST_ACTIVE : tgt_sr ? ST_SR_CMD : ST_PD_ENTER;
            ST_PD_ENTER: next = ST_PD;
            ST_PD:       next = tmr_done && (wake_req || sr_req || !pd_en) ? ST_PD_EXIT : ST_PD;
            ST_PD_EXIT:  next = tmr_done ? ST_ACTIVE : ST_PD_EXIT;
            ST_SR_CMD:   next = ST_SR;
            ST_SR:       next = tmr_done && !sr_req ? ST_SR_EXIT : ST_SR;
            ST_SR_EXIT:  next = tmr_done ? ST_ACTIVE : ST_SR_EXIT;
            default:     next = ST_ACTIVE;
        endcase
    end

    // Outputs are registered decodes of the current state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cke_pad                                        <= 1'b1;
            {csbar_pad, rasbar_pad, casbar_pad, webar_pad} <= CMD_DES;
            eng_hold                                       <= 1'b0;
            bus_own                                        <= 1'b0;
            pd_active                                      <= 1'b0;
            sr_active                                      <= 1'b0;
        end else begin
            cke_pad                                        <= !(state inside {ST_PD_ENTER, ST_PD, ST_SR});
            {csbar_pad, rasbar_pad, casbar_pad, webar_pad} <= state == ST_SR_CMD ? CMD_REF :
                                                              state inside {ST_HOLD, ST_PD_EXIT, ST_SR_EXIT} ? CMD_NOP : CMD_DES;
            eng_hold                                       <= state != ST_ACTIVE;
            bus_own                                        <= state != ST_ACTIVE;
            pd_active                                      <= state inside {ST_PD_ENTER, ST_PD};
            sr_active                                      <= state inside {ST_SR_CMD, ST_SR, ST_SR_EXIT};
        end
    end
endmodule

// File: tb/tb_ddr2_power_ctrl.sv
// tb_ddr2_power_ctrl: scenario bench for ddr2_power_ctrl with randomized timing and arithmetic expectations.
module tb_ddr2_power_ctrl;
    localparam int IDLE_THRESH = 16;
    localparam int T_CKE       = 3;
    localparam int T_XP        = 2;
    localparam int T_XSNR      = 140;

    logic clk = 1'b0;
    logic reset, eng_idle, pd_en, sr_req, wake_req;
    logic eng_hold, bus_own, cke_pad, csbar_pad, rasbar_pad, casbar_pad, webar_pad, pd_active, sr_active;
    logic [3:0] cmd;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    assign cmd = {csbar_pad, rasbar_pad, casbar_pad, webar_pad};

    always #5 clk = ~clk;

    ddr2_power_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .eng_idle   (eng_idle),
        .pd_en      (pd_en),
        .sr_req     (sr_req),
        .wake_req   (wake_req),
        .eng_hold   (eng_hold),
        .bus_own    (bus_own),
        .cke_pad    (cke_pad),
        .csbar_pad  (csbar_pad),
        .rasbar_pad (rasbar_pad),
        .casbar_pad (casbar_pad),
        .webar_pad  (webar_pad),
        .pd_active  (pd_active),
        .sr_active  (sr_active)
    );

    // Power monitor: only deselect while CKE is low; engine stall and bus ownership always agree.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!cke_pad && cmd !== 4'b1111) begin
                errors++;
                $display("FAIL mon_cke_low_cmd: cmd=%b while cke=0, required 1111", cmd);
            end
            checks++;
            if (bus_own !== eng_hold) begin
                errors++;
                $display("FAIL mon_own_hold: bus_own=%b eng_hold=%b, required equal", bus_own, eng_hold);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int max2(int a, int b);
        return a > b ? a : b;
    endfunction

    task automatic test_reset();
        reset = 1'b1; eng_idle = 1'b0; pd_en = 1'b0; sr_req = 1'b0; wake_req = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cke_pad, cmd} !== 5'b11111) begin errors++; $display("FAIL reset_pads: got %b required 11111", {cke_pad, cmd}); end
        checks++;
        if ({eng_hold, bus_own} !== 2'b00) begin errors++; $display("FAIL reset_hold_own: got %b required 00", {eng_hold, bus_own}); end
        checks++;
        if ({pd_active, sr_active} !== 2'b00) begin errors++; $display("FAIL reset_status: got %b required 00", {pd_active, sr_active}); end
        reset = 1'b0;
        mon_en = 1'b1;
    endtask

    // Random non-idle prefix (bursts too short to count out), then a steady idle run.
    task automatic test_pd_entry();
        int pre, fall, hold_up;
        pd_en = 1'b1; wake_req = 1'b0;
        pre = $urandom_range(0, 10);
        repeat (pre) begin eng_idle = 1'($urandom_range(0, 1)); tick(); end
        eng_idle = 1'b0; tick();
        eng_idle = 1'b1;
        fall = 0; hold_up = 0;
        for (int n = 1; n <= 40 && fall == 0; n++) begin
            tick();
            if (eng_hold && hold_up == 0) hold_up = n;
            if (!cke_pad) fall = n;
        end
        checks++;
        if (hold_up != IDLE_THRESH + 1) begin errors++; $display("FAIL pd_hold_cycle: got %0d required %0d", hold_up, IDLE_THRESH + 1); end
        checks++;
        if (fall != IDLE_THRESH + 2) begin errors++; $display("FAIL pd_cke_fall_cycle: got %0d required %0d", fall, IDLE_THRESH + 2); end
        checks++;
        if (pd_active !== 1'b1) begin errors++; $display("FAIL pd_active_on: got %b required 1", pd_active); end
    endtask

    // Called right after the CKE fall edge; wake arrives j cycles into power-down.
    task automatic test_pd_wake();
        int j, k, rise, drop, exp_rise;
        j = $urandom_range(0, 6);
        repeat (j) tick();
        wake_req = 1'b1;
        exp_rise = max2(T_CKE + 1, j + 2);
        k = j; rise = 0; drop = 0;
        for (int i = 0; i < 60 && drop == 0; i++) begin
            tick(); k++;
            if (rise == 0 && cke_pad) rise = k;
            if (rise != 0 && !eng_hold) drop = k;
        end
        checks++;
        if (rise != exp_rise) begin errors++; $display("FAIL pd_wake_cke_rise: got %0d required %0d (j=%0d)", rise, exp_rise, j); end
        checks++;
        if (drop - rise != T_XP) begin errors++; $display("FAIL pd_wake_release: got %0d required %0d", drop - rise, T_XP); end
        checks++;
        if (pd_active !== 1'b0) begin errors++; $display("FAIL pd_active_off: got %b required 0", pd_active); end
        wake_req = 1'b0; pd_en = 1'b0;
        tick();
    endtask

    task automatic test_hold_abort();
        int fall, drop;
        pd_en = 1'b0; eng_idle = 1'b0; tick();
        pd_en = 1'b1; eng_idle = 1'b1;
        repeat (IDLE_THRESH) tick();
        eng_idle = 1'b0;
        tick();
        checks++;
        if ({eng_hold, cke_pad} !== 2'b11) begin errors++; $display("FAIL abort_hold: got %b required 11", {eng_hold, cke_pad}); end
        tick();
        checks++;
        if ({eng_hold, cke_pad} !== 2'b01) begin errors++; $display("FAIL abort_release: got %b required 01", {eng_hold, cke_pad}); end
        eng_idle = 1'b1;
        fall = 0;
        for (int n = 1; n <= 40 && fall == 0; n++) begin
            tick();
            if (!cke_pad) fall = n;
        end
        checks++;
        if (fall != IDLE_THRESH + 2) begin errors++; $display("FAIL abort_restart_fall: got %0d required %0d", fall, IDLE_THRESH + 2); end
        pd_en = 1'b0;
        drop = 0;
        for (int n = 1; n <= 30 && drop == 0; n++) begin
            tick();
            if (!eng_hold) drop = n;
        end
        checks++;
        if (drop == 0 || cke_pad !== 1'b1) begin errors++; $display("FAIL abort_pd_exit: drop=%0d cke=%b required release with cke=1", drop, cke_pad); end
        eng_idle = 1'b0;
        tick();
    endtask

    task automatic test_self_refresh();
        int l, k, rise, drop, exp_rise;
        bit sr_at_rise;
        pd_en = 1'b0; eng_idle = 1'b1; wake_req = 1'b0; sr_req = 1'b1;
        tick();
        tick();
        checks++;
        if ({eng_hold, cke_pad, cmd} !== 6'b110111) begin errors++; $display("FAIL sr_hold_nop: got %b required 110111", {eng_hold, cke_pad, cmd}); end
        tick();
        checks++;
        if ({cke_pad, cmd, sr_active} !== 6'b100011) begin errors++; $display("FAIL sr_ref_cmd: got %b required 100011", {cke_pad, cmd, sr_active}); end
        tick();
        checks++;
        if ({cke_pad, csbar_pad} !== 2'b01) begin errors++; $display("FAIL sr_cke_low: got %b required 01", {cke_pad, csbar_pad}); end
        l = $urandom_range(0, 20);
        repeat (l) begin wake_req = 1'($urandom_range(0, 1)); tick(); end
        sr_req = 1'b0; wake_req = 1'b0;
        exp_rise = max2(T_CKE, l + 2);
        k = l; rise = 0; drop = 0; sr_at_rise = 1'b0;
        for (int i = 0; i < 400 && drop == 0; i++) begin
            tick(); k++;
            if (rise == 0 && cke_pad) begin rise = k; sr_at_rise = sr_active; end
            if (rise != 0 && !eng_hold) drop = k;
        end
        checks++;
        if (rise != exp_rise) begin errors++; $display("FAIL sr_cke_rise: got %0d required %0d (l=%0d)", rise, exp_rise, l); end
        checks++;
        if (drop - rise != T_XSNR) begin errors++; $display("FAIL sr_release: got %0d required %0d", drop - rise, T_XSNR); end
        checks++;
        if ({sr_at_rise, sr_active} !== 2'b10) begin errors++; $display("FAIL sr_active_span: got %b required 10", {sr_at_rise, sr_active}); end
        eng_idle = 1'b0;
        tick();
    endtask

    // Self-refresh requested while in power-down must exit, pass through ACTIVE, then re-enter via HOLD.
    task automatic test_sr_from_pd();
        int j, k, fall, rise, exp_rise;
        pd_en = 1'b1; eng_idle = 1'b1;
        fall = 0;
        for (int n = 1; n <= 40 && fall == 0; n++) begin
            tick();
            if (!cke_pad) fall = n;
        end
        checks++;
        if (fall == 0) begin errors++; $display("FAIL srpd_enter_pd: cke never fell, required fall"); end
        j = $urandom_range(0, 6);
        repeat (j) tick();
        sr_req = 1'b1;
        exp_rise = max2(T_CKE + 1, j + 2);
        k = j; rise = 0;
        for (int i = 0; i < 40 && rise == 0; i++) begin
            tick(); k++;
            if (cke_pad) rise = k;
        end
        checks++;
        if (rise != exp_rise) begin errors++; $display("FAIL srpd_cke_rise: got %0d required %0d", rise, exp_rise); end
        tick();
        checks++;
        if (eng_hold !== 1'b1) begin errors++; $display("FAIL srpd_exit_tail: eng_hold=%b required 1", eng_hold); end
        tick();
        checks++;
        if (eng_hold !== 1'b0) begin errors++; $display("FAIL srpd_active: eng_hold=%b required 0", eng_hold); end
        tick();
        checks++;
        if ({eng_hold, cke_pad, cmd} !== 6'b110111) begin errors++; $display("FAIL srpd_hold: got %b required 110111", {eng_hold, cke_pad, cmd}); end
        tick();
        checks++;
        if ({cke_pad, cmd} !== 5'b10001) begin errors++; $display("FAIL srpd_ref: got %b required 10001", {cke_pad, cmd}); end
        tick();
        checks++;
        if ({cke_pad, sr_active, pd_active} !== 3'b010) begin errors++; $display("FAIL srpd_in_sr: got %b required 010", {cke_pad, sr_active, pd_active}); end
    endtask

    task automatic test_reset_in_sr();
        repeat ($urandom_range(0, 3)) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({cke_pad, cmd} !== 5'b11111) begin errors++; $display("FAIL sr_reset_pads: got %b required 11111", {cke_pad, cmd}); end
        checks++;
        if ({eng_hold, bus_own, sr_active} !== 3'b000) begin errors++; $display("FAIL sr_reset_status: got %b required 000", {eng_hold, bus_own, sr_active}); end
        reset = 1'b0; sr_req = 1'b0; eng_idle = 1'b0; pd_en = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cke_pad, eng_hold} !== 2'b10) begin errors++; $display("FAIL sr_reset_after: got %b required 10", {cke_pad, eng_hold}); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pd_entry();
        test_pd_wake();
        test_hold_abort();
        test_self_refresh();
        test_sr_from_pd();
        test_reset_in_sr();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr2_power_ctrl.md
Name: ddr2_power_ctrl

Overview:
Sequences DDR2 CKE-driven low-power modes: precharge power-down and self-refresh. It sits between the protocol engine and the pad mux. It decides entry and exit, holds the engine off while the DRAM is unavailable, and owns the command bus during transitions. Its bus behaviour satisfies the team rule that only NOP/deselect appears while CKE=0.

Parameters:
IDLE_THRESH, 16, consecutive eng_idle cycles (with pd_en) before power-down entry; 1..255
T_CKE, 3, minimum cycles CKE stays low; 1..255
T_XP, 2, cycles after power-down exit before engine is released; 1..255
T_XSNR, 140, cycles after self-refresh exit before engine is released; 1..255

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high
eng_idle  in  1  engine has no pending command and all banks are precharged
pd_en  in  1  power-down enable
sr_req  in  1  level: self-refresh requested
wake_req  in  1  level: new work pending; requests power-down exit
eng_hold  out  1  engine must not issue commands
bus_own  out  1  pad mux selects this block's command outputs
cke_pad  out  1  CKE
csbar_pad  out  1  CS#
rasbar_pad  out  1  RAS#
casbar_pad  out  1  CAS#
webar_pad  out  1  WE#
pd_active  out  1  in power-down
sr_active  out  1  in self-refresh sequence

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=ACTIVE, cke_pad=1, csbar/rasbar/casbar/webar=1, eng_hold=0, bus_own=0, pd_active=0, sr_active=0, all counters 0.
- Reset asserted mid-operation returns to ACTIVE at the next edge. No exit timing is honoured; the DRAM is re-initialised by the system.
- States: ACTIVE, HOLD, PD_ENTER, PD, PD_EXIT, SR_CMD, SR, SR_EXIT.
- idle_cnt (8-bit, saturating): increments while eng_idle&pd_en in ACTIVE; otherwise clears.
- ACTIVE:
  - sr_req&eng_idle → HOLD with target=SR. Self-refresh has priority.
  - Else idle_cnt==IDLE_THRESH-1 & eng_idle & !wake_req → HOLD with target=PD.
- HOLD (1 cycle): eng_hold=1, bus_own=1, NOP.
  - If eng_idle is still 1 → PD_ENTER or SR_CMD per target.
  - Else abort → ACTIVE, clearing eng_hold and idle_cnt.
- PD_ENTER: cke_pad=0, load timer=T_CKE-1, pd_active=1 → PD.
- PD: cke_pad=0, csbar=1. When timer==0 and (wake_req|sr_req|!pd_en) → PD_EXIT.
- PD_EXIT: cke_pad=1, NOP, load timer=T_XP-1. Stay until timer==0, then → ACTIVE, with eng_hold=0 and bus_own=0 on the following cycle.
- SR_CMD (1 cycle): cke_pad=1, drive REF (csbar=0, rasbar=0, casbar=0, webar=1), sr_active=1 → SR. CKE drops the cycle after the command, never with it.
- SR: cke_pad=0, csbar=1. Timer is loaded with T_CKE-1 on entry. When timer==0 and !sr_req → SR_EXIT.
- SR_EXIT: cke_pad=1, NOP, load timer=T_XSNR-1. At timer==0 → ACTIVE and sr_active=0.
- eng_hold=1 and bus_own=1 in every state except ACTIVE.
- In every state with cke_pad=0, csbar_pad=1.
- sr_req arriving during PD exits via PD_EXIT → ACTIVE, then re-enters through HOLD. There is no direct PD→SR path.
- wake_req during SR is ignored; only sr_req deassertion exits self-refresh.
- The timer is an 8-bit down-counter and never wraps: it holds at 0.

Decomposition:
- ddr2_power_pkg holds:
  - state enum
  - CMD_NOP and CMD_REF 4-bit {cs,ras,cas,we} encodings
  - TIMER_W=8
- Sub-module ddr2_power_timer: loadable 8-bit down-counter with load/value inputs and a done output. One instance, shared across the timed states.

Test Plan:
- pd_en=1, eng_idle=1 held → cke_pad falls at cycle 18 after reset release (16 idle + HOLD + PD_ENTER). eng_hold is high from cycle 17.
- In PD, pulse wake_req at PD cycle 1 → exit waits until cke has been low for 3 cycles. cke=1, then eng_hold drops 2 cycles later.
- sr_req=1 with eng_idle=1 → HOLD, then one REF cycle with cke=1, then cke=0 with csbar=1 throughout. Deassert sr_req → eng_hold clears 140 cycles after cke rises.
- eng_idle drops during HOLD → returns to ACTIVE, cke never falls, idle_cnt restarts from 0.
- sr_req asserted while in PD → sequence PD_EXIT (2 cycles), ACTIVE, HOLD, SR_CMD, SR. No non-NOP command is seen while cke=0 (power monitor attached).
- reset asserted during SR → next edge cke_pad=1, all bus outputs=1, eng_hold=0.
